pc_unit: RTL and testbench

Fetch-side program counter and branch-resolution block of the 5-stage CPU. It holds the fetch PC and predicts taken branches and jumps with a small direct-mapped branch target buffer (BTB) of 2-bit counters. It consumes the branch comparator result from EX, detects mispredictions, and redirects fetch with a one-cycle pipeline flush. It sits between the comparator/EX stage (upstream of its resolution inputs) and the instruction fetch port (downstream of its PC output).

---
 rtl/pc_unit_pkg.sv | 29 ++
 rtl/pc_unit_btb.sv | 73 +++++++
 rtl/pc_unit.sv | 96 +++++++++
 tb/tb_pc_unit.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_unit_pkg.sv
// Shared constants and types for the fetch PC / branch-target-buffer slice.
package pc_unit_pkg;

    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam int unsigned BTB_IDX_W_DEF = 4;

    // 2-bit saturating predictor counter; the MSB is the taken prediction.
    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    // One saturating step of the predictor counter toward taken (up) or not taken.
    function automatic ctr_e ctr_step(input ctr_e cur, input logic up);
        ctr_e nxt;
        nxt = cur;
        case (cur)
            CTR_SNT: nxt = up ? CTR_WNT : CTR_SNT;
            CTR_WNT: nxt = up ? CTR_WT  : CTR_SNT;
            CTR_WT:  nxt = up ? CTR_ST  : CTR_WNT;
            CTR_ST:  nxt = up ? CTR_ST  : CTR_WT;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/pc_unit_btb.sv
// Direct-mapped branch target buffer: one combinational lookup port and one
// resolution write port that owns the counter update / allocation policy.
module btb
    import pc_unit_pkg::*;
#(
    parameter int unsigned IDX_W = BTB_IDX_W_DEF
)(
    input  logic               clk,
    input  logic               rst,
    input  logic [IDX_W-1:0]   rd_idx,
    input  logic [29-IDX_W:0]  rd_tag,
    output logic               rd_taken,
    output logic [31:0]        rd_target,
    input  logic               wr_en,
    input  logic               wr_is_br,
    input  logic               wr_taken,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [29-IDX_W:0]  wr_tag,
    input  logic [31:0]        wr_target
);

    localparam int unsigned ENTRIES = 1 << IDX_W;
    localparam int unsigned TAG_W   = 30 - IDX_W;

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag_mem [ENTRIES];
    logic [31:0]        tgt_mem [ENTRIES];
    ctr_e               ctr_mem [ENTRIES];

    logic rd_hit;
    logic wr_hit;
    logic wr_entry;
    ctr_e wr_ctr;

    // Fetch-side lookup: taken only on a valid tag hit with counter MSB set.
    always_comb begin
        rd_hit    = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
        rd_taken  = rd_hit && (ctr_mem[rd_idx] inside {CTR_WT, CTR_ST});
        rd_target = tgt_mem[rd_idx];
    end

    // Resolution write decision: hit branches train, taken-miss branches
    // allocate weakly taken, jumps always install strongly taken.
    always_comb begin
        wr_hit   = valid[wr_idx] && (tag_mem[wr_idx] == wr_tag);
        wr_entry = wr_en && (!wr_is_br || wr_hit || wr_taken);
        wr_ctr   = CTR_ST;
        if (wr_is_br) begin
            wr_ctr = wr_hit ? ctr_step(ctr_mem[wr_idx], wr_taken) : CTR_WT;
        end
    end

    // Valid bits are the only BTB state that reset clears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (wr_entry) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Tag, counter and target storage; target only rewritten on taken outcomes.
    always_ff @(posedge clk) begin
        if (wr_entry) begin
            tag_mem[wr_idx] <= wr_tag;
            ctr_mem[wr_idx] <= wr_ctr;
            if (wr_taken) begin
                tgt_mem[wr_idx] <= wr_target;
            end
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter with BTB prediction and EX-stage branch resolution.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter int unsigned BTB_IDX_W = BTB_IDX_W_DEF
)(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    output logic [31:0] o_pc,
    output logic        o_pred_taken,
    output logic [31:0] o_pred_target,
    input  logic        i_ex_valid,
    input  logic [31:0] i_ex_pc,
    input  logic        i_ex_is_br,
    input  logic        i_ex_is_jal,
    input  logic        i_ex_is_jalr,
    input  logic        i_ex_cmp_res,
    input  logic [31:0] i_ex_imm,
    input  logic [31:0] i_ex_rs1,
    input  logic        i_ex_pred_taken,
    input  logic [31:0] i_ex_pred_target,
    output logic        o_flush,
    output logic        o_misalign
);

    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        btb_taken;
    logic [31:0] btb_target;
    logic        resolve;
    logic        taken;
    logic        mispredict;
    logic        misalign;
    logic [31:0] target;
    logic [31:0] redirect_pc;

    btb #(
        .IDX_W (BTB_IDX_W)
    ) u_btb (
        .clk       (i_clk),
        .rst       (i_rst),
        .rd_idx    (pc[BTB_IDX_W+1:2]),
        .rd_tag    (pc[31:BTB_IDX_W+2]),
        .rd_taken  (btb_taken),
        .rd_target (btb_target),
        .wr_en     (resolve && !misalign),
        .wr_is_br  (i_ex_is_br),
        .wr_taken  (taken),
        .wr_idx    (i_ex_pc[BTB_IDX_W+1:2]),
        .wr_tag    (i_ex_pc[31:BTB_IDX_W+2]),
        .wr_target (target)
    );

    // Fetch-side prediction for the current PC.
    always_comb begin
        o_pc          = pc;
        o_pred_taken  = btb_taken;
        o_pred_target = btb_taken ? btb_target : pc + 32'd4;
    end

    // EX resolution: actual outcome, target, mispredict and misalignment.
    always_comb begin
        resolve     = i_ex_valid && (i_ex_is_br || i_ex_is_jal || i_ex_is_jalr);
        taken       = resolve && (i_ex_is_br ? i_ex_cmp_res : 1'b1);
        target      = i_ex_is_jalr ? ((i_ex_rs1 + i_ex_imm) & ~32'h1)
                                   : (i_ex_pc + i_ex_imm);
        mispredict  = resolve && ((taken != i_ex_pred_taken) ||
                                  (taken && (target != i_ex_pred_target)));
        misalign    = taken && (target[1:0] != 2'b00);
        redirect_pc = taken ? target : i_ex_pc + 32'd4;
        o_flush     = mispredict;
        o_misalign  = misalign;
    end

    // Next-PC priority: redirect beats stall, stall beats prediction.
    always_comb begin
        next_pc = o_pred_target;
        if (mispredict) begin
            next_pc = redirect_pc;
        end else if (i_stall) begin
            next_pc = pc;
        end
    end

    // Fetch PC register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= next_pc;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed vector table, hand sequences for
// multi-cycle corners, and a randomized run against a behavioural model.
module tb_pc_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_pc = '0;
    logic        ex_br = 1'b0, ex_jal = 1'b0, ex_jalr = 1'b0, ex_cmp = 1'b0;
    logic [31:0] ex_imm = '0, ex_rs1 = '0;
    logic        ex_pt = 1'b0;
    logic [31:0] ex_ptg = '0;
    logic        flush;
    logic        misalign;

    int errors = 0;
    int checks = 0;

    pc_unit #(
        .RESET_PC  (RST_PC),
        .BTB_IDX_W (4)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_stall          (stall),
        .o_pc             (pc),
        .o_pred_taken     (pred_taken),
        .o_pred_target    (pred_target),
        .i_ex_valid       (ex_valid),
        .i_ex_pc          (ex_pc),
        .i_ex_is_br       (ex_br),
        .i_ex_is_jal      (ex_jal),
        .i_ex_is_jalr     (ex_jalr),
        .i_ex_cmp_res     (ex_cmp),
        .i_ex_imm         (ex_imm),
        .i_ex_rs1         (ex_rs1),
        .i_ex_pred_taken  (ex_pt),
        .i_ex_pred_target (ex_ptg),
        .o_flush          (flush),
        .o_misalign       (misalign)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural model: 16 entries keyed by word address
    bit          m_v   [16];
    logic [29:0] m_own [16];
    logic [31:0] m_tgt [16];
    int          m_ctr [16];
    logic [31:0] m_pc;

    function automatic int slot(input logic [31:0] a);
        return int'((a >> 2) % 16);
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        return m_v[slot(a)] && (m_own[slot(a)] == 30'(a >> 2));
    endfunction

    function automatic bit m_pred(input logic [31:0] a);
        return m_hit(a) && (m_ctr[slot(a)] >= 2);
    endfunction

    function automatic logic [31:0] m_ptgt(input logic [31:0] a);
        return m_pred(a) ? m_tgt[slot(a)] : a + 32'd4;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_set(input logic br, input logic jal, input logic jalr, input logic cmp,
                          input logic [31:0] p, input logic [31:0] imm, input logic [31:0] rs1,
                          input logic pt, input logic [31:0] ptg);
        ex_valid = 1'b1;
        ex_br = br; ex_jal = jal; ex_jalr = jalr; ex_cmp = cmp;
        ex_pc = p; ex_imm = imm; ex_rs1 = rs1; ex_pt = pt; ex_ptg = ptg;
    endtask

    task automatic ex_idle();
        ex_valid = 1'b0;
        ex_br = 1'b0; ex_jal = 1'b0; ex_jalr = 1'b0; ex_cmp = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        stall = 1'b0;
        ex_idle();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    typedef struct {
        logic        v, br, jal, jalr, cmp;
        logic [31:0] p, imm, rs1;
        logic        pt;
        logic [31:0] ptg;
        logic        exp_flush, exp_mis;
    } vec_t;

    vec_t vecs[11];

    initial begin
        // v br jal jalr cmp  pc  imm  rs1  pt  ptg  flush mis
        vecs[0]  = '{1'b0,1'b1,1'b0,1'b0,1'b1, 32'h200, 32'h40, 32'h0, 1'b0, 32'h0, 1'b0,1'b0};
        vecs[1]  = '{1'b1,1'b1,1'b0,1'b0,1'b1, 32'h200, 32'h40, 32'h0, 1'b1, 32'h240, 1'b0,1'b0};
        vecs[2]  = '{1'b1,1'b1,1'b0,1'b0,1'b1, 32'h200, 32'h40, 32'h0, 1'b1, 32'h244, 1'b1,1'b0};
        vecs[3]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, 32'h200, 32'h40, 32'h0, 1'b0, 32'h999, 1'b0,1'b0};
        vecs[4]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, 32'h200, 32'h40, 32'h0, 1'b1, 32'h240, 1'b1,1'b0};
        vecs[5]  = '{1'b1,1'b0,1'b1,1'b0,1'b0, 32'h300, 32'hFFFF_FFF8, 32'h0, 1'b0, 32'h0, 1'b1,1'b0};
        vecs[6]  = '{1'b1,1'b0,1'b0,1'b1,1'b0, 32'h400, 32'h0, 32'h1003, 1'b1, 32'h1002, 1'b0,1'b1};
        vecs[7]  = '{1'b1,1'b0,1'b1,1'b0,1'b0, 32'hFFFF_FFFC, 32'h8, 32'h0, 1'b1, 32'h4, 1'b0,1'b0};
        vecs[8]  = '{1'b1,1'b1,1'b0,1'b0,1'b1, 32'h200, 32'h42, 32'h0, 1'b0, 32'h0, 1'b1,1'b1};
        vecs[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b1, 32'h200, 32'h40, 32'h0, 1'b1, 32'h0, 1'b0,1'b0};
        vecs[10] = '{1'b1,1'b0,1'b0,1'b1,1'b0, 32'h500, 32'h1, 32'h2001, 1'b1, 32'h2002, 1'b0,1'b1};

        // ---------------- reset state and sequential fetch
        do_reset();
        chk("reset_pc", pc, RST_PC);
        chk("reset_pred_taken", 32'(pred_taken), 32'h0);
        chk("reset_pred_target", pred_target, RST_PC + 32'd4);
        chk("reset_flush", 32'(flush), 32'h0);
        chk("reset_misalign", 32'(misalign), 32'h0);
        tick();
        chk("seq_pc1", pc, 32'h104);
        chk("seq_pred1", 32'(pred_taken), 32'h0);
        tick();
        chk("seq_pc2", pc, 32'h108);
        chk("seq_pred2", 32'(pred_taken), 32'h0);

        // ---------------- table of resolution vectors
        for (int i = 0; i < 11; i++) begin
            ex_set(vecs[i].br, vecs[i].jal, vecs[i].jalr, vecs[i].cmp, vecs[i].p,
                   vecs[i].imm, vecs[i].rs1, vecs[i].pt, vecs[i].ptg);
            ex_valid = vecs[i].v;
            #1;
            chk($sformatf("vec%0d_flush", i), 32'(flush), 32'(vecs[i].exp_flush));
            chk($sformatf("vec%0d_misalign", i), 32'(misalign), 32'(vecs[i].exp_mis));
            tick();
        end
        ex_idle();

        // ---------------- taken branch trains BTB
        do_reset();
        ex_set(1, 0, 0, 1, 32'h200, 32'h40, 0, 0, 0);
        #1 chk("beq_flush", 32'(flush), 32'h1);
        chk("beq_misalign", 32'(misalign), 32'h0);
        tick(); ex_idle();
        chk("beq_redirect_pc", pc, 32'h240);
        ex_set(0, 1, 0, 0, 32'h1F0, 32'h10, 0, 0, 0);
        tick(); ex_idle();
        chk("refetch_pc", pc, 32'h200);
        chk("refetch_pred_taken", 32'(pred_taken), 32'h1);
        chk("refetch_pred_target", pred_target, 32'h240);

        // ---------------- predicted taken, resolved not taken
        ex_set(1, 0, 0, 0, 32'h200, 32'h40, 0, 1, 32'h240);
        #1 chk("nt_flush", 32'(flush), 32'h1);
        tick(); ex_idle();
        chk("nt_redirect_pc", pc, 32'h204);
        ex_set(0, 1, 0, 0, 32'h1F0, 32'h10, 0, 0, 0);
        tick(); ex_idle();
        chk("nt_refetch_pc", pc, 32'h200);
        chk("nt_refetch_pred", 32'(pred_taken), 32'h0);
        chk("nt_refetch_target", pred_target, 32'h204);

        // ---------------- misaligned JALR: flush and redirect, no BTB write
        ex_set(0, 0, 1, 0, 32'h400, 32'h0, 32'h1003, 0, 0);
        #1 chk("jalr_misalign", 32'(misalign), 32'h1);
        chk("jalr_flush", 32'(flush), 32'h1);
        tick(); ex_idle();
        chk("jalr_pc", pc, 32'h1002);
        chk("jalr_pred_target", pred_target, 32'h1006);
        ex_set(0, 1, 0, 0, 32'h3F0, 32'h10, 0, 0, 0);
        tick(); ex_idle();
        chk("jalr_nowrite_pc", pc, 32'h400);
        chk("jalr_nowrite_pred", 32'(pred_taken), 32'h0);

        // ---------------- redirect during stall, then hold
        stall = 1'b1;
        ex_set(0, 1, 0, 0, 32'h2F0, 32'h10, 0, 0, 0);
        tick(); ex_idle();
        chk("stall_redirect_pc", pc, 32'h300);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall_hold%0d", i), pc, 32'h300);
        end
        stall = 1'b0;

        // ---------------- asynchronous reset mid-cycle clears training
        ex_set(1, 0, 0, 1, 32'h200, 32'h40, 0, 0, 0);
        tick();
        ex_set(0, 1, 0, 0, 32'h1F0, 32'h10, 0, 0, 0);
        tick(); ex_idle();
        chk("retrain_pc", pc, 32'h200);
        chk("retrain_pred", 32'(pred_taken), 32'h1);
        #2 rst = 1'b1;
        #1 chk("async_rst_pc", pc, RST_PC);
        chk("async_rst_pred", 32'(pred_taken), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        ex_set(0, 1, 0, 0, 32'h1F0, 32'h10, 0, 0, 0);
        tick(); ex_idle();
        chk("post_rst_pc", pc, 32'h200);
        chk("post_rst_pred", 32'(pred_taken), 32'h0);

        // ---------------- randomized run against the model
        do_reset();
        for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
        m_pc = RST_PC;
        for (int n = 0; n < 2000; n++) begin
            logic        act, tk, mis, mal, hit;
            logic [31:0] tgt, nxt;
            int          cls, s;

            cls   = int'($urandom_range(0, 7));
            stall = ($urandom_range(0, 3) == 0);
            ex_valid = ($urandom_range(0, 3) != 0);
            ex_br   = (cls <= 3);
            ex_jal  = (cls == 4 || cls == 5);
            ex_jalr = (cls == 6);
            ex_cmp  = 1'($urandom_range(0, 1));
            ex_pc   = 32'h100 + 32'($urandom_range(0, 47)) * 4;
            ex_imm  = 32'($urandom_range(0, 15)) * 4 - 32'd32;
            if ($urandom_range(0, 15) == 0) ex_imm = ex_imm + 32'd2;
            ex_rs1  = 32'h100 + 32'($urandom_range(0, 47)) * 4 + 32'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                ex_pt  = m_pred(ex_pc);
                ex_ptg = m_ptgt(ex_pc);
            end else begin
                ex_pt  = 1'($urandom_range(0, 1));
                ex_ptg = ($urandom_range(0, 1) == 1) ? ex_pc + ex_imm : ex_pc + 32'd4;
            end

            act = ex_valid && (ex_br || ex_jal || ex_jalr);
            tk  = act && (ex_br ? ex_cmp : 1'b1);
            tgt = ex_jalr ? ((ex_rs1 + ex_imm) & 32'hFFFF_FFFE) : ex_pc + ex_imm;
            mis = act && ((tk != ex_pt) || (tk && tgt != ex_ptg));
            mal = tk && (tgt % 4 != 0);
            if (mis) nxt = tk ? tgt : ex_pc + 32'd4;
            else if (stall) nxt = m_pc;
            else nxt = m_ptgt(m_pc);

            #1;
            chk("rnd_pc", pc, m_pc);
            chk("rnd_pred_taken", 32'(pred_taken), 32'(m_pred(m_pc)));
            chk("rnd_pred_target", pred_target, m_ptgt(m_pc));
            chk("rnd_flush", 32'(flush), 32'(mis));
            chk("rnd_misalign", 32'(misalign), 32'(mal));

            s   = slot(ex_pc);
            hit = m_hit(ex_pc);
            if (act && !mal) begin
                if (ex_br) begin
                    if (hit) begin
                        m_ctr[s] = tk ? ((m_ctr[s] == 3) ? 3 : m_ctr[s] + 1)
                                      : ((m_ctr[s] == 0) ? 0 : m_ctr[s] - 1);
                        if (tk) m_tgt[s] = tgt;
                    end else if (tk) begin
                        m_v[s] = 1'b1; m_own[s] = 30'(ex_pc >> 2); m_tgt[s] = tgt; m_ctr[s] = 2;
                    end
                end else begin
                    m_v[s] = 1'b1; m_own[s] = 30'(ex_pc >> 2); m_tgt[s] = tgt; m_ctr[s] = 3;
                end
            end
            m_pc = nxt;
            tick();
        end
        ex_idle();
        stall = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
